// File: rtl/chipid_pkg.sv
// Shared types and constants for the chip-ID Avalon-MM controller.
// Word-count and address-width helpers keep the top and the bench in agreement.
package chipid_pkg;

   typedef enum logic [1:0] {
      S_PULSE   = 2'd0,
      S_WAIT    = 2'd1,
      S_VALID   = 2'd2,
      S_TIMEOUT = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MODE_ZERO   = 2'd0,
      MODE_WAIT   = 2'd1,
      MODE_STATUS = 2'd2
   } mode_e;

   localparam int STAT_VALID   = 0;
   localparam int STAT_TIMEOUT = 1;
   localparam int STAT_BUSY    = 2;

   localparam int CTRL_RESTART = 0;
   localparam int CTRL_IRQ_EN  = 1;

   function automatic int chipid_words(input int id_width);
      return id_width / 32;
   endfunction

   // ID words plus STATUS and CONTROL
   function automatic int chipid_aw(input int id_width);
      return $clog2(id_width / 32 + 2);
   endfunction

endpackage

// File: rtl/chipid_avm_ctrl_if.sv
// Avalon-MM slave port of the chip-ID controller.
interface chipid_avm_ctrl_if #(
   parameter int AW = 2
);
   logic [AW-1:0] chipid_address;
   logic          chipid_read;
   logic          chipid_write;
   logic [31:0]   chipid_writedata;
   logic [31:0]   chipid_readdata;
   logic          chipid_waitrequest;

   modport master (
      output chipid_address, chipid_read, chipid_write, chipid_writedata,
      input  chipid_readdata, chipid_waitrequest
   );

   modport slave (
      input  chipid_address, chipid_read, chipid_write, chipid_writedata,
      output chipid_readdata, chipid_waitrequest
   );
endinterface

// File: rtl/chipid_seq.sv
// ID-source sequencer: reset pulse, wait-for-valid with timeout, and the ID snapshot.
// S_VALID and S_TIMEOUT hold until a restart request.
module chipid_seq
   import chipid_pkg::*;
#(
   parameter int ID_WIDTH       = 64,
   parameter int RESET_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                restart,
   input  logic [ID_WIDTH-1:0] id_in,
   input  logic                id_valid_in,
   output state_e              state,
   output logic [ID_WIDTH-1:0] snapshot,
   output logic                id_reset
);

   localparam logic [31:0] PULSE_LAST  = 32'(RESET_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

   state_e              state_reg, state_next;
   logic [31:0]         cnt_reg, cnt_next;
   logic [ID_WIDTH-1:0] snap_reg, snap_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_PULSE;
         cnt_reg   <= '0;
         snap_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         snap_reg  <= snap_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      snap_next  = snap_reg;
      if (restart) begin
         state_next = S_PULSE;
         cnt_next   = '0;
         snap_next  = '0;
      end else begin
         case (state_reg)
            S_PULSE: begin
               if (cnt_reg == PULSE_LAST) begin
                  state_next = S_WAIT;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 32'd1;
               end
            end
            S_WAIT: begin
               cnt_next = cnt_reg + 32'd1;
               // A capture in the expiry cycle takes precedence over the timeout
               if (id_valid_in) begin
                  snap_next  = id_in;
                  state_next = S_VALID;
               end else if ((TIMEOUT_CYCLES != 0) && (cnt_next == TIMEOUT_LIM)) begin
                  state_next = S_TIMEOUT;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign state    = state_reg;
   assign snapshot = snap_reg;
   assign id_reset = (state_reg == S_PULSE);

endmodule

// File: rtl/chipid_avm_ctrl.sv
// Avalon-MM register front end for the chip-ID sequencer: address decode,
// registered read path with one-cycle ack, validity policy, CONTROL and irq.
module chipid_avm_ctrl
   import chipid_pkg::*;
#(
   parameter int    ID_WIDTH       = 64,
   parameter string VALIDITY_MODE  = "ZERO",
   parameter int    RESET_CYCLES   = 4,
   parameter int    TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                reset,
   chipid_avm_ctrl_if.slave    bus,
   input  logic [ID_WIDTH-1:0] id_in,
   input  logic                id_valid_in,
   output logic                id_reset,
   output logic                irq
);

   localparam int    N  = chipid_words(ID_WIDTH);
   localparam int    AW = chipid_aw(ID_WIDTH);
   localparam mode_e MODE = (VALIDITY_MODE == "WAIT")   ? MODE_WAIT :
                            (VALIDITY_MODE == "STATUS") ? MODE_STATUS : MODE_ZERO;
   localparam logic [AW-1:0] ADDR_STATUS  = AW'(N);
   localparam logic [AW-1:0] ADDR_CONTROL = AW'(N + 1);

   state_e              state;
   logic [ID_WIDTH-1:0] snapshot;
   logic                valid, timeout, busy;
   logic                wr_ok, restart, id_sel, rd_hold, rd_accept;
   logic                ack_reg, ack_next;
   logic                irq_en_reg, irq_en_next;
   logic [31:0]         rdata_reg, rdata_next;
   logic [31:0]         rd_mux, status_word, control_word;
   logic [31:0]         id_words [N];
   logic                unused_wdata;

   chipid_seq #(
      .ID_WIDTH       (ID_WIDTH),
      .RESET_CYCLES   (RESET_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_seq (
      .clk         (clk),
      .reset       (reset),
      .restart     (restart),
      .id_in       (id_in),
      .id_valid_in (id_valid_in),
      .state       (state),
      .snapshot    (snapshot),
      .id_reset    (id_reset)
   );

   assign valid   = (state == S_VALID);
   assign timeout = (state == S_TIMEOUT);
   assign busy    = (state == S_PULSE) || (state == S_WAIT);

   // A concurrent read takes the bus; the write is dropped
   assign wr_ok   = bus.chipid_write & ~bus.chipid_read;
   assign restart = wr_ok && (bus.chipid_address == ADDR_CONTROL)
                    && bus.chipid_writedata[CTRL_RESTART];
   assign unused_wdata = &{1'b0, bus.chipid_writedata[31:2]};

   // The snapshot is zero until a capture, so only the ZERO policy needs gating
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_id_word
         assign id_words[gi] = ((MODE == MODE_ZERO) && !valid) ? 32'd0
                                                               : snapshot[32*gi +: 32];
      end
   endgenerate

   always_comb begin
      status_word               = '0;
      status_word[STAT_VALID]   = valid;
      status_word[STAT_TIMEOUT] = timeout;
      status_word[STAT_BUSY]    = busy;
      control_word              = '0;
      control_word[CTRL_IRQ_EN] = irq_en_reg;
   end

   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < N; k++) begin
         if (bus.chipid_address == AW'(k)) rd_mux = id_words[k];
      end
      if (bus.chipid_address == ADDR_STATUS)  rd_mux = status_word;
      if (bus.chipid_address == ADDR_CONTROL) rd_mux = control_word;
   end

   assign id_sel    = (bus.chipid_address < ADDR_STATUS);
   assign rd_hold   = (MODE == MODE_WAIT) && id_sel && busy;
   assign rd_accept = bus.chipid_read & ~ack_reg & ~rd_hold;

   always_comb begin
      ack_next    = rd_accept;
      rdata_next  = rd_accept ? rd_mux : rdata_reg;
      irq_en_next = irq_en_reg;
      if (wr_ok && (bus.chipid_address == ADDR_CONTROL)) begin
         irq_en_next = bus.chipid_writedata[CTRL_IRQ_EN];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_reg    <= 1'b0;
         rdata_reg  <= '0;
         irq_en_reg <= 1'b0;
      end else begin
         ack_reg    <= ack_next;
         rdata_reg  <= rdata_next;
         irq_en_reg <= irq_en_next;
      end
   end

   // A held read simply never sees ack until the hold drops
   assign bus.chipid_waitrequest = bus.chipid_read & ~ack_reg & ~reset;
   assign bus.chipid_readdata    = rdata_reg;
   assign irq                    = irq_en_reg & (valid | timeout);

endmodule

// File: tb/tb_chipid_avm_ctrl.sv
// Scoreboard bench for chipid_avm_ctrl: four configurations share one master,
// reads push expectations and a negedge monitor pops them on completion.
module tb_chipid_avm_ctrl;
   import chipid_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         m_read, m_write;
   logic [2:0]   m_addr;
   logic [31:0]  m_wdata;
   logic [127:0] id_in;
   logic         id_valid;
   int           sel;
   bit           mon_en;
   int           n_checks = 0;
   int           n_fail = 0;
   exp_t         exp_q[$];
   exp_t         mon_e;

   logic [3:0]   idr, irqv;
   logic [31:0]  cur_rdata;
   logic         cur_wait, cur_idr, cur_irq;

   always #5 clk = ~clk;

   chipid_avm_ctrl_if #(.AW(2)) bus0 ();
   chipid_avm_ctrl_if #(.AW(2)) bus1 ();
   chipid_avm_ctrl_if #(.AW(2)) bus2 ();
   chipid_avm_ctrl_if #(.AW(3)) bus3 ();

   assign bus0.chipid_read      = m_read && (sel == 0);
   assign bus0.chipid_write     = m_write && (sel == 0);
   assign bus0.chipid_address   = m_addr[1:0];
   assign bus0.chipid_writedata = m_wdata;
   assign bus1.chipid_read      = m_read && (sel == 1);
   assign bus1.chipid_write     = m_write && (sel == 1);
   assign bus1.chipid_address   = m_addr[1:0];
   assign bus1.chipid_writedata = m_wdata;
   assign bus2.chipid_read      = m_read && (sel == 2);
   assign bus2.chipid_write     = m_write && (sel == 2);
   assign bus2.chipid_address   = m_addr[1:0];
   assign bus2.chipid_writedata = m_wdata;
   assign bus3.chipid_read      = m_read && (sel == 3);
   assign bus3.chipid_write     = m_write && (sel == 3);
   assign bus3.chipid_address   = m_addr;
   assign bus3.chipid_writedata = m_wdata;

   chipid_avm_ctrl #(.ID_WIDTH(64), .VALIDITY_MODE("ZERO"), .RESET_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .id_in(id_in[63:0]), .id_valid_in(id_valid),
      .id_reset(idr[0]), .irq(irqv[0]));
   chipid_avm_ctrl #(.ID_WIDTH(64), .VALIDITY_MODE("WAIT"), .RESET_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .id_in(id_in[63:0]), .id_valid_in(id_valid),
      .id_reset(idr[1]), .irq(irqv[1]));
   chipid_avm_ctrl #(.ID_WIDTH(64), .VALIDITY_MODE("WAIT"), .RESET_CYCLES(4), .TIMEOUT_CYCLES(16)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2), .id_in(id_in[63:0]), .id_valid_in(id_valid),
      .id_reset(idr[2]), .irq(irqv[2]));
   chipid_avm_ctrl #(.ID_WIDTH(128), .VALIDITY_MODE("STATUS"), .RESET_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3), .id_in(id_in), .id_valid_in(id_valid),
      .id_reset(idr[3]), .irq(irqv[3]));

   always_comb begin
      case (sel)
         1:       begin cur_rdata = bus1.chipid_readdata; cur_wait = bus1.chipid_waitrequest; end
         2:       begin cur_rdata = bus2.chipid_readdata; cur_wait = bus2.chipid_waitrequest; end
         3:       begin cur_rdata = bus3.chipid_readdata; cur_wait = bus3.chipid_waitrequest; end
         default: begin cur_rdata = bus0.chipid_readdata; cur_wait = bus0.chipid_waitrequest; end
      endcase
      cur_idr = idr[sel[1:0]];
      cur_irq = irqv[sel[1:0]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Completion monitor: a read finishes when it is presented without a stall
   always @(negedge clk) begin
      if (mon_en && !reset && m_read && !cur_wait) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_read: got %h, expected no completion", cur_rdata);
         end else begin
            mon_e = exp_q.pop_front();
            check(mon_e.name, cur_rdata, mon_e.exp);
            $display("read  dut%0d %s addr=%0d data=%h", sel, mon_e.name, m_addr, cur_rdata);
         end
      end
   end

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name,
                     input int budget = 10);
      exp_t e;
      int   n;
      e.name = name;
      e.exp  = exp;
      exp_q.push_back(e);
      m_addr = a;
      m_read = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cur_wait && n < budget);
      if (cur_wait) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: read still stalled after %0d cycles, expected completion", name, budget);
         e = exp_q.pop_back();
      end
      @(posedge clk);
      #1 m_read = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input string name);
      m_addr  = a;
      m_wdata = d;
      m_write = 1'b1;
      @(negedge clk);
      check({name, "_waitrequest"}, 32'(cur_wait), 32'd0);
      $display("write dut%0d %s addr=%0d data=%h", sel, name, a, d);
      @(posedge clk);
      #1 m_write = 1'b0;
   endtask

   task automatic do_reset(input int s);
      sel      = s;
      m_read   = 1'b0;
      m_write  = 1'b0;
      id_valid = 1'b0;
      mon_en   = 1'b1;
      reset    = 1'b1;
      @(negedge clk);
      check("rst_readdata", cur_rdata, 32'd0);
      check("rst_waitrequest", 32'(cur_wait), 32'd0);
      check("rst_id_reset", 32'(cur_idr), 32'd1);
      check("rst_irq", 32'(cur_irq), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic pulse_valid();
      id_valid = 1'b1;
      @(posedge clk);
      #1 id_valid = 1'b0;
   endtask

   initial begin
      m_read = 0; m_write = 0; m_addr = 0; m_wdata = 0;
      id_in = '0; id_valid = 0; sel = 0; mon_en = 1;

      // ZERO policy, capture, then restart with irq enabled
      id_in = 128'h0123_4567_89AB_CDEF;
      do_reset(0);
      rd(3'd0, 32'h0, "zero_pre_valid");
      repeat (22) @(posedge clk);
      #1;
      pulse_valid();
      rd(3'd0, 32'h89AB_CDEF, "zero_word0");
      rd(3'd1, 32'h0123_4567, "zero_word1");
      rd(3'd2, 32'h1, "zero_status");
      id_in = 128'hFFFF_0000_1234_5678;
      wr(3'd3, 32'h3, "ctrl_restart");
      fork
         begin
            int c = 0;
            repeat (10) begin
               @(negedge clk);
               if (cur_idr) c++;
            end
            check("restart_pulse_len", 32'(c), 32'd4);
         end
         rd(3'd2, 32'h4, "status_busy");
      join
      @(posedge clk);
      #1;
      check("irq_before_valid", 32'(cur_irq), 32'd0);
      pulse_valid();
      check("irq_after_valid", 32'(cur_irq), 32'd1);
      rd(3'd0, 32'h1234_5678, "restart_word0");
      rd(3'd1, 32'hFFFF_0000, "restart_word1");
      rd(3'd3, 32'h2, "ctrl_readback");

      // WAIT policy: early read held until capture
      id_in = 128'h0123_4567_89AB_CDEF;
      do_reset(1);
      repeat (2) @(posedge clk);
      #1;
      fork
         rd(3'd1, 32'h0123_4567, "wait_word1", 100);
         begin
            repeat (48) @(posedge clk);
            #1;
            pulse_valid();
         end
         begin
            repeat (48) @(negedge clk);
            check("wait_held", 32'(cur_wait), 32'd1);
         end
      join
      rd(3'd2, 32'h1, "wait_status");

      // WAIT policy with timeout 16, valid never arrives
      do_reset(2);
      rd(3'd0, 32'h0, "timeout_held_word0", 60);
      rd(3'd2, 32'h2, "timeout_status");
      do_reset(2);
      repeat (18) @(posedge clk);
      #1;
      rd(3'd2, 32'h4, "timeout_edge_busy");
      rd(3'd2, 32'h2, "timeout_edge_set");

      // Valid in the expiry cycle wins; snapshot then frozen
      id_in = 128'hCAFE_F00D_DEAD_BEEF;
      do_reset(2);
      repeat (19) @(posedge clk);
      #1;
      pulse_valid();
      rd(3'd2, 32'h1, "coincide_status");
      id_in = '1;
      pulse_valid();
      rd(3'd0, 32'hDEAD_BEEF, "snap_hold_word0");
      rd(3'd1, 32'hCAFE_F00D, "snap_hold_word1");

      // 128-bit STATUS policy, out-of-range access, reset mid-read
      id_in = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      do_reset(3);
      rd(3'd0, 32'h0, "status_pre_capture");
      repeat (10) @(posedge clk);
      #1;
      pulse_valid();
      rd(3'd0, 32'hCCDD_EEFF, "w128_word0");
      rd(3'd1, 32'h8899_AABB, "w128_word1");
      rd(3'd2, 32'h4455_6677, "w128_word2");
      rd(3'd3, 32'h0011_2233, "w128_word3");
      rd(3'd4, 32'h1, "w128_status");
      rd(3'd7, 32'h0, "oor_read");
      wr(3'd7, 32'hFFFF_FFFF, "oor_write");
      rd(3'd5, 32'h0, "ctrl_after_oor");
      rd(3'd4, 32'h1, "status_after_oor");
      check("irq_after_oor", 32'(cur_irq), 32'd0);
      mon_en = 1'b0;
      m_addr = 3'd0;
      m_read = 1'b1;
      @(posedge clk);
      #1;
      check("midread_loaded", cur_rdata, 32'hCCDD_EEFF);
      #2 reset = 1'b1;
      #1;
      check("midread_rst_readdata", cur_rdata, 32'h0);
      check("midread_rst_waitrequest", 32'(cur_wait), 32'd0);
      m_read = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      mon_en = 1'b1;
      rd(3'd0, 32'h0, "reissue_after_reset");

      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
